// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// and reports the WIDTH-bit difference plus the final borrow with a done pulse.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_bit, b_bit, d_bit, br_next;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor slice on the current LSBs of the operand shift registers
  always_comb begin
    a_bit     = a_sh_q[0];
    b_bit     = b_sh_q[0];
    d_bit     = a_bit ^ b_bit ^ br_q;
    br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_shift = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = res_shift;
        br_d   = br_next;
        // The counter stops on the last bit so it can never wrap
        if (cnt_q == LAST_BIT) begin
          state_d  = S_DONE;
          diff_d   = res_shift;
          borrow_d = br_next;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed bench for subtrator_serial: a cycle-level behavioural model checked
// every cycle, plus literal expectations for the listed operand cases.
module tb_subtrator_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  subtrator_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an accepted op keeps busy for W cycles, then done for one cycle
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bo = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic         p_bo = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_diff <= '0; m_bo <= 1'b0;
      p_diff <= '0; p_bo <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_done <= 1'b1; m_diff <= p_diff; m_bo <= p_bo;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      m_left <= W;
      p_diff <= W'(int'(a_i) - int'(b_i));
      p_bo   <= (int'(a_i) < int'(b_i));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("borrow_out", 32'(borrow_out), 32'(m_bo));
  end

  task automatic wait_pos();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input string nm,
                        output int bc);
    bit found = 0;
    bc = 0;
    wait_pos();
    start = 1'b1; a_i = av; b_i = bv;
    wait_pos();
    start = 1'b0; a_i = W'($urandom); b_i = W'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
      if (busy) bc++;
    end
    chk({nm, "_done_seen"}, 32'(found), 32'd1);
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int nd;
    int d1, d2;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    #5 rst = 1'b0;

    run_op(8'd5, 8'd3, 8'h02, 1'b0, "5m3", bc);
    chk("5m3_busy_cycles", 32'(bc), 32'd8);
    run_op(8'd3, 8'd5, 8'hFE, 1'b1, "3m5", bc);
    run_op(8'd0, 8'd1, 8'hFF, 1'b1, "0m1", bc);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "FFmFF", bc);
    run_op(8'd0, 8'd0, 8'h00, 1'b0, "0m0", bc);
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, "80m7F", bc);

    // Start and operand changes during BUSY are ignored
    wait_pos();
    start = 1'b1; a_i = 8'd9; b_i = 8'd4;
    wait_pos();
    start = 1'b0; a_i = 8'hAA; b_i = 8'h55;
    wait_pos();
    wait_pos();
    start = 1'b1; a_i = 8'd1; b_i = 8'd2;
    wait_pos();
    start = 1'b0; a_i = 8'h33; b_i = 8'hCC;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk("ign_diff", 32'(diff), 32'h05);
        chk("ign_borrow", 32'(borrow_out), 32'd0);
      end
    end
    chk("ign_done_count", 32'(nd), 32'd1);

    // Reset mid-operation
    run_op(8'd3, 8'd5, 8'hFE, 1'b1, "pre_rst", bc);
    wait_pos();
    start = 1'b1; a_i = 8'd7; b_i = 8'd1;
    wait_pos();
    start = 1'b0;
    wait_pos();
    wait_pos();
    wait_pos();
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow", 32'(borrow_out), 32'd0);
    wait_pos();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst_no_done", 32'(nd), 32'd0);
    run_op(8'd7, 8'd1, 8'h06, 1'b0, "post_rst", bc);

    // Back-to-back with start held high
    wait_pos();
    start = 1'b1; a_i = 8'd10; b_i = 8'd4;
    nd = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) d1 = cyc; else d2 = cyc;
        chk("b2b_diff", 32'(diff), 32'h06);
        chk("b2b_borrow", 32'(borrow_out), 32'd0);
        if (nd == 2) break;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(nd), 32'd2);
    chk("b2b_spacing", 32'(d2 - d1), 32'd10);

    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
